e203_ifu_jalr_sched: RTL and testbench
======================================

Name: e203_ifu_jalr_sched

Overview:
- IFU-side branch-target scheduler. Consumes the IFU mini-decoder outputs (jal/jalr/bxx flags, bjp immediate, jalr rs1 index) for each newly fetched instruction.
- Produces a predicted next-PC.
- For JALR, sequences the rs1 operand fetch: waits out data hazards, arbitrates for the regfile read port shared with EXU decode, then captures the operand.
- Stalls fetch (bpu_wait) while a JALR target is unresolved.

Parameters:
- XLEN, 32, data/PC width
- RFIDX_W, 5, register index width
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dec_valid  in  1  new instruction presented to mini-decoder this cycle
- dec_jal  in  1  decoded JAL
- dec_jalr  in  1  decoded JALR
- dec_bxx  in  1  decoded conditional branch
- dec_jalr_rs1idx  in  RFIDX_W  JALR rs1 index
- dec_bjp_imm  in  XLEN  sign-extended branch/jump immediate
- pc  in  XLEN  PC of presented instruction
- flush  in  1  pipeline flush; abort any pending resolution
- oitf_empty  in  1  no long-pipe instruction outstanding
- ir_valid  in  1  IR stage holds a valid instruction
- ir_rden  in  1  IR instruction writes rd
- ir_rdidx  in  RFIDX_W  IR instruction rd index
- rf_x1  in  XLEN  dedicated x1 copy from regfile
- rs1_req  out  1  request for shared regfile read port
- rs1_gnt  in  1  read port granted this cycle
- rs1_idx  out  RFIDX_W  index to read
- rs1_rdata  in  XLEN  read data, valid the cycle after grant
- bpu_wait  out  1  stall fetch
- tgt_valid  out  1  one-cycle pulse: predicted target available
- prdt_taken  out  1  prediction taken (qualified by tgt_valid)
- tgt_pc  out  XLEN  predicted target
- stall_cnt  out  CNT_W  saturating count of cycles with bpu_wait=1

Behaviour:
- Reset: FSM=IDLE. All outputs 0, including stall_cnt.
- dec_valid is sampled only in IDLE. It is ignored in all other states.
- FSM states: IDLE, WAIT_DEP, REQ, RDATA.
- Accept in IDLE with dec_valid=1, non-JALR cases. Result appears next cycle with tgt_valid=1 (1-cycle latency); FSM stays in IDLE.
  - JAL: prdt_taken=1, tgt_pc=pc+imm.
  - BXX: prdt_taken=imm[XLEN-1] (backward taken, forward not), tgt_pc=pc+imm.
  - Anything else: no tgt_valid.
- JALR with rs1=x0: tgt_pc=imm with bit0 cleared, prdt_taken=1, 1-cycle latency, no stall.
- JALR with any other rs1:
  - Latch pc, imm and rs1idx. Assert bpu_wait in the same cycle. Go to WAIT_DEP.
  - WAIT_DEP → REQ when oitf_empty=1 and hazard=0, where hazard = ir_valid & ir_rden & (ir_rdidx==rs1idx).
  - REQ: rs1_req=1, rs1_idx=latched idx. Held until rs1_gnt=1, then go to RDATA.
  - RDATA: tgt_pc=(rs1_rdata+imm) with bit0 cleared, tgt_valid=1, prdt_taken=1. bpu_wait drops in this same cycle. Return to IDLE.
- All additions are XLEN-bit and wrap modulo 2^XLEN.
- flush (highest priority): FSM→IDLE next cycle. rs1_req, bpu_wait and any pending tgt_valid are suppressed the cycle after flush. A grant coinciding with flush is discarded; no target is produced. A dec_valid coinciding with flush is dropped.
- stall_cnt increments each cycle bpu_wait=1 and saturates at all-ones. It clears only on rst.
- rst mid-operation: immediate return to IDLE. rs1_req deasserts next cycle.

Optional Feature:
- E203_JALR_X1_FWD_EN defined: JALR with rs1=x1 bypasses the read port.
  - In WAIT_DEP, once oitf_empty=1 and hazard=0, the block goes directly to result.
  - tgt_pc=(rf_x1+imm) with bit0 cleared and tgt_valid=1 in the cycle after the hazard clears.
  - rs1_req is never asserted for x1.
- Undefined: x1 follows the general REQ/RDATA path, and the rf_x1 port is unused.

Decomposition:
- Shared package (e203_defines): FSM state encodings, XLEN/RFIDX defaults, x0/x1 index constants.
- One natural sub-module: e203_ifu_jalr_dep_chk, a combinational hazard check (oitf_empty, IR rd match) used in WAIT_DEP.

Test Plan:
- JAL, pc=0x100, imm=0x20 → next cycle tgt_valid=1, prdt_taken=1, tgt_pc=0x120, bpu_wait never 1.
- BXX, pc=0x200, imm=-8 → tgt_pc=0x1F8, prdt_taken=1; then imm=+8 → tgt_pc=0x208, prdt_taken=0.
- JALR rs1=x5, imm=3, IR writing x5 for 2 cycles, gnt delayed 3 cycles, rdata=0x1000 → rs1_req held 3 cycles, tgt_pc=0x1002, stall_cnt increments by the exact bpu_wait cycle count.
- JALR rs1=x5 and flush asserted in the cycle rs1_gnt=1 → no tgt_valid, FSM back in IDLE, next JAL handled normally.
- JALR rs1=x1, rf_x1=0x8000, imm=0 → with E203_JALR_X1_FWD_EN: tgt_pc=0x8000, rs1_req never 1; without: request/grant path taken, same target.
- stall_cnt with CNT_W=4 and a 20-cycle oitf_empty=0 stall → saturates at 15; rst clears it to 0.

Source files
------------

// File: rtl/e203_defines.sv
// Shared constants and FSM state encoding for the IFU JALR target scheduler.
package e203_defines;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned RFIDX_W_DEF = 5;
  localparam int unsigned CNT_W_DEF   = 16;

  localparam int unsigned RF_IDX_X0 = 0;
  localparam int unsigned RF_IDX_X1 = 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_DEP = 2'd1,
    ST_REQ      = 2'd2,
    ST_RDATA    = 2'd3
  } jalr_state_e;

endpackage

// File: rtl/e203_ifu_jalr_dep_chk.sv
// Combinational check that the JALR rs1 operand is safe to read:
// no long-pipe op outstanding and no IR-stage writer of the same register.
module e203_ifu_jalr_dep_chk #(
  parameter int unsigned RFIDX_W = 5
) (
  input  logic               oitf_empty_i,
  input  logic               ir_valid_i,
  input  logic               ir_rden_i,
  input  logic [RFIDX_W-1:0] ir_rdidx_i,
  input  logic [RFIDX_W-1:0] rs1_idx_i,
  output logic               dep_clr_c_o
);

  logic ir_hazard;

  assign ir_hazard   = ir_valid_i & ir_rden_i & (ir_rdidx_i == rs1_idx_i);
  assign dep_clr_c_o = oitf_empty_i & ~ir_hazard;

endmodule

// File: rtl/e203_ifu_jalr_sched.sv
// IFU branch-target scheduler: predicts next PC for JAL/BXX/JALR and sequences
// the JALR rs1 fetch. Optional x1 bypass enabled by E203_JALR_X1_FWD_EN.
module e203_ifu_jalr_sched
  import e203_defines::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned RFIDX_W = RFIDX_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_valid,
  input  logic               dec_jal,
  input  logic               dec_jalr,
  input  logic               dec_bxx,
  input  logic [RFIDX_W-1:0] dec_jalr_rs1idx,
  input  logic [XLEN-1:0]    dec_bjp_imm,
  input  logic [XLEN-1:0]    pc,
  input  logic               flush,
  input  logic               oitf_empty,
  input  logic               ir_valid,
  input  logic               ir_rden,
  input  logic [RFIDX_W-1:0] ir_rdidx,
  input  logic [XLEN-1:0]    rf_x1,
  output logic               rs1_req,
  input  logic               rs1_gnt,
  output logic [RFIDX_W-1:0] rs1_idx,
  input  logic [XLEN-1:0]    rs1_rdata,
  output logic               bpu_wait,
  output logic               tgt_valid,
  output logic               prdt_taken,
  output logic [XLEN-1:0]    tgt_pc,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [XLEN-1:0]    LSB_CLR = ~XLEN'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [RFIDX_W-1:0] IDX_X0  = RFIDX_W'(RF_IDX_X0);
  localparam logic [RFIDX_W-1:0] IDX_X1  = RFIDX_W'(RF_IDX_X1);

  jalr_state_e        state_q, state_d;
  logic [XLEN-1:0]    imm_q, imm_d;
  logic [RFIDX_W-1:0] idx_q, idx_d;
  logic               rs1_req_q, rs1_req_d;
  logic [RFIDX_W-1:0] rs1_idx_q, rs1_idx_d;
  logic               bpu_wait_q, bpu_wait_d;
  logic               tgt_valid_q, tgt_valid_d;
  logic               prdt_taken_q, prdt_taken_d;
  logic [XLEN-1:0]    tgt_pc_q, tgt_pc_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               dep_clr;
  logic [XLEN-1:0]    pc_sum;
  logic [XLEN-1:0]    rs1_sum;
  logic [XLEN-1:0]    x1_sum;

  e203_ifu_jalr_dep_chk #(
    .RFIDX_W (RFIDX_W)
  ) u_dep_chk (
    .oitf_empty_i (oitf_empty),
    .ir_valid_i   (ir_valid),
    .ir_rden_i    (ir_rden),
    .ir_rdidx_i   (ir_rdidx),
    .rs1_idx_i    (idx_q),
    .dep_clr_c_o  (dep_clr)
  );

`ifdef E203_JALR_X1_FWD_EN
  localparam bit X1_FWD = 1'b1;
  assign x1_sum = rf_x1 + imm_q;
`else
  localparam bit X1_FWD = 1'b0;
  logic unused_rf_x1;
  assign x1_sum      = '0;
  assign unused_rf_x1 = ^rf_x1;
`endif

  assign pc_sum  = pc + dec_bjp_imm;
  assign rs1_sum = rs1_rdata + imm_q;

  // Next-state and registered-output computation; flush overrides at the end.
  always_comb begin
    state_d      = state_q;
    imm_d        = imm_q;
    idx_d        = idx_q;
    rs1_req_d    = 1'b0;
    rs1_idx_d    = '0;
    bpu_wait_d   = 1'b0;
    tgt_valid_d  = 1'b0;
    prdt_taken_d = 1'b0;
    tgt_pc_d     = tgt_pc_q;
    stall_cnt_d  = (bpu_wait_q && (stall_cnt_q != CNT_MAX)) ?
                   stall_cnt_q + CNT_W'(1) : stall_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (dec_valid) begin
          if (dec_jal) begin
            tgt_valid_d  = 1'b1;
            prdt_taken_d = 1'b1;
            tgt_pc_d     = pc_sum;
          end else if (dec_jalr) begin
            if (dec_jalr_rs1idx == IDX_X0) begin
              tgt_valid_d  = 1'b1;
              prdt_taken_d = 1'b1;
              tgt_pc_d     = dec_bjp_imm & LSB_CLR;
            end else begin
              imm_d      = dec_bjp_imm;
              idx_d      = dec_jalr_rs1idx;
              bpu_wait_d = 1'b1;
              state_d    = ST_WAIT_DEP;
            end
          end else if (dec_bxx) begin
            tgt_valid_d  = 1'b1;
            prdt_taken_d = dec_bjp_imm[XLEN-1];
            tgt_pc_d     = pc_sum;
          end
        end
      end
      ST_WAIT_DEP: begin
        bpu_wait_d = 1'b1;
        if (dep_clr) begin
          if (X1_FWD && (idx_q == IDX_X1)) begin
            bpu_wait_d   = 1'b0;
            tgt_valid_d  = 1'b1;
            prdt_taken_d = 1'b1;
            tgt_pc_d     = x1_sum & LSB_CLR;
            state_d      = ST_IDLE;
          end else begin
            rs1_req_d = 1'b1;
            rs1_idx_d = idx_q;
            state_d   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        bpu_wait_d = 1'b1;
        if (rs1_gnt) begin
          state_d = ST_RDATA;
        end else begin
          rs1_req_d = 1'b1;
          rs1_idx_d = idx_q;
        end
      end
      ST_RDATA: begin
        tgt_valid_d  = 1'b1;
        prdt_taken_d = 1'b1;
        tgt_pc_d     = rs1_sum & LSB_CLR;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d      = ST_IDLE;
      rs1_req_d    = 1'b0;
      rs1_idx_d    = '0;
      bpu_wait_d   = 1'b0;
      tgt_valid_d  = 1'b0;
      prdt_taken_d = 1'b0;
      tgt_pc_d     = tgt_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      imm_q        <= '0;
      idx_q        <= '0;
      rs1_req_q    <= 1'b0;
      rs1_idx_q    <= '0;
      bpu_wait_q   <= 1'b0;
      tgt_valid_q  <= 1'b0;
      prdt_taken_q <= 1'b0;
      tgt_pc_q     <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      imm_q        <= imm_d;
      idx_q        <= idx_d;
      rs1_req_q    <= rs1_req_d;
      rs1_idx_q    <= rs1_idx_d;
      bpu_wait_q   <= bpu_wait_d;
      tgt_valid_q  <= tgt_valid_d;
      prdt_taken_q <= prdt_taken_d;
      tgt_pc_q     <= tgt_pc_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign rs1_req    = rs1_req_q;
  assign rs1_idx    = rs1_idx_q;
  assign bpu_wait   = bpu_wait_q;
  assign tgt_valid  = tgt_valid_q;
  assign prdt_taken = prdt_taken_q;
  assign tgt_pc     = tgt_pc_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_e203_ifu_jalr_sched.sv
// Bench for e203_ifu_jalr_sched: directed scenarios plus random traffic checked
// cycle by cycle against a transaction-level reference model.
module tb_e203_ifu_jalr_sched;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RFIDX_W = 5;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_TOP = (1 << CNT_W) - 1;
  localparam logic [31:0] MASK    = 32'hFFFF_FFFE;
`ifdef E203_JALR_X1_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, dec_valid, dec_jal, dec_jalr, dec_bxx;
  logic [RFIDX_W-1:0] dec_jalr_rs1idx, ir_rdidx, rs1_idx;
  logic [XLEN-1:0]    dec_bjp_imm, pc, rf_x1, rs1_rdata, tgt_pc;
  logic               flush, oitf_empty, ir_valid, ir_rden;
  logic               rs1_req, rs1_gnt, bpu_wait, tgt_valid, prdt_taken;
  logic [CNT_W-1:0]   stall_cnt;

  e203_ifu_jalr_sched #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_jal(dec_jal),
    .dec_jalr(dec_jalr), .dec_bxx(dec_bxx), .dec_jalr_rs1idx(dec_jalr_rs1idx),
    .dec_bjp_imm(dec_bjp_imm), .pc(pc), .flush(flush), .oitf_empty(oitf_empty),
    .ir_valid(ir_valid), .ir_rden(ir_rden), .ir_rdidx(ir_rdidx), .rf_x1(rf_x1),
    .rs1_req(rs1_req), .rs1_gnt(rs1_gnt), .rs1_idx(rs1_idx),
    .rs1_rdata(rs1_rdata), .bpu_wait(bpu_wait), .tgt_valid(tgt_valid),
    .prdt_taken(prdt_taken), .tgt_pc(tgt_pc), .stall_cnt(stall_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one JALR transaction in flight, described by its phase.
  bit          m_busy = 1'b0;
  bit          m_rd   = 1'b0;
  logic [31:0] m_imm  = '0;
  logic [4:0]  m_idx  = '0;
  bit          e_tv = 1'b0, e_pr = 1'b0, e_wait = 1'b0, e_req = 1'b0;
  logic [31:0] e_tpc = '0;
  int          e_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit tv, pr, wt, rq;
    logic [31:0] tp;
    int cnt;
    cnt = e_wait ? ((e_cnt < CNT_TOP) ? e_cnt + 1 : CNT_TOP) : e_cnt;
    tv = 0; pr = 0; wt = 0; rq = 0; tp = e_tpc;
    if (rst) begin
      m_busy = 0; m_rd = 0; tp = '0; cnt = 0;
    end else if (flush) begin
      m_busy = 0; m_rd = 0;
    end else if (m_rd) begin
      tv = 1; pr = 1; tp = (rs1_rdata + m_imm) & MASK;
      m_rd = 0; m_busy = 0;
    end else if (e_req) begin
      wt = 1;
      if (rs1_gnt) m_rd = 1;
      else rq = 1;
    end else if (m_busy) begin
      wt = 1;
      if (oitf_empty && !(ir_valid && ir_rden && ir_rdidx == m_idx)) begin
        if (FWD && m_idx == 5'd1) begin
          wt = 0; tv = 1; pr = 1; tp = (rf_x1 + m_imm) & MASK; m_busy = 0;
        end else begin
          rq = 1;
        end
      end
    end else if (dec_valid) begin
      if (dec_jal) begin
        tv = 1; pr = 1; tp = pc + dec_bjp_imm;
      end else if (dec_jalr) begin
        if (dec_jalr_rs1idx == 5'd0) begin
          tv = 1; pr = 1; tp = dec_bjp_imm & MASK;
        end else begin
          m_busy = 1; m_imm = dec_bjp_imm; m_idx = dec_jalr_rs1idx; wt = 1;
        end
      end else if (dec_bxx) begin
        tv = 1; pr = dec_bjp_imm[31]; tp = pc + dec_bjp_imm;
      end
    end
    e_tv = tv; e_pr = pr; e_wait = wt; e_req = rq; e_tpc = tp; e_cnt = cnt;
  endtask

  // Advance one clock, then compare every output against the model.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("tgt_valid", 32'(tgt_valid), 32'(e_tv));
    chk("bpu_wait", 32'(bpu_wait), 32'(e_wait));
    chk("rs1_req", 32'(rs1_req), 32'(e_req));
    chk("stall_cnt", 32'(stall_cnt), 32'(e_cnt));
    if (e_tv) begin
      chk("prdt_taken", 32'(prdt_taken), 32'(e_pr));
      chk("tgt_pc", tgt_pc, e_tpc);
    end
    if (e_req) chk("rs1_idx", 32'(rs1_idx), 32'(m_idx));
  endtask

  task automatic idle_in();
    rst = 0; dec_valid = 0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
    dec_jalr_rs1idx = '0; dec_bjp_imm = '0; pc = '0; flush = 0;
    oitf_empty = 1; ir_valid = 0; ir_rden = 0; ir_rdidx = '0;
    rf_x1 = '0; rs1_gnt = 0; rs1_rdata = '0;
  endtask

  task automatic present(input bit jal, input bit jalr, input bit bxx,
                         input logic [4:0] idx, input logic [31:0] p, input logic [31:0] imm);
    idle_in();
    dec_valid = 1; dec_jal = jal; dec_jalr = jalr; dec_bxx = bxx;
    dec_jalr_rs1idx = idx; pc = p; dec_bjp_imm = imm;
  endtask

  int reqs;
  bit seen;

  initial begin
    idle_in();
    rst = 1;
    step();
    step();
    chk("rst_rs1_idx", 32'(rs1_idx), 32'd0);
    chk("rst_tgt_pc", tgt_pc, 32'd0);
    chk("rst_prdt", 32'(prdt_taken), 32'd0);

    // JAL
    present(1, 0, 0, 5'd0, 32'h100, 32'h20);
    step();
    chk("jal_pc", tgt_pc, 32'h120);
    idle_in(); step();

    // BXX backward then forward
    present(0, 0, 1, 5'd0, 32'h200, 32'hFFFF_FFF8);
    step();
    chk("bxx_back_pc", tgt_pc, 32'h1F8);
    chk("bxx_back_taken", 32'(prdt_taken), 32'd1);
    present(0, 0, 1, 5'd0, 32'h200, 32'h8);
    step();
    chk("bxx_fwd_pc", tgt_pc, 32'h208);
    chk("bxx_fwd_taken", 32'(prdt_taken), 32'd0);
    idle_in(); step();

    // JALR x0
    present(0, 1, 0, 5'd0, 32'h300, 32'h0000_0457);
    step();
    chk("jalr_x0_pc", tgt_pc, 32'h456);
    idle_in(); step();

    // JALR x5: IR hazard 2 cycles, grant after 3 request cycles
    reqs = 0;
    present(0, 1, 0, 5'd5, 32'h400, 32'h3);
    step();
    idle_in(); ir_valid = 1; ir_rden = 1; ir_rdidx = 5'd5;
    step(); step();
    idle_in(); step();
    reqs += int'(rs1_req);
    step(); reqs += int'(rs1_req);
    step(); reqs += int'(rs1_req);
    rs1_gnt = 1; step();
    idle_in(); rs1_rdata = 32'h1000; step();
    chk("jalr_x5_req_cycles", 32'(reqs), 32'd3);
    chk("jalr_x5_pc", tgt_pc, 32'h1002);
    chk("jalr_x5_stall", 32'(stall_cnt), 32'd7);
    idle_in(); step();

    // JALR x5 aborted by flush coinciding with grant
    present(0, 1, 0, 5'd5, 32'h500, 32'h10);
    step();
    idle_in(); step();
    rs1_gnt = 1; flush = 1; rs1_rdata = 32'hDEAD_0000; step();
    idle_in(); rs1_rdata = 32'h1234_5678; step();
    chk("flush_no_tgt", 32'(tgt_valid), 32'd0);
    present(1, 0, 0, 5'd0, 32'h600, 32'h4);
    step();
    chk("post_flush_jal", tgt_pc, 32'h604);
    idle_in(); step();

    // JALR x1 with rf_x1 = 0x8000
    reqs = 0; seen = 0;
    present(0, 1, 0, 5'd1, 32'h700, 32'h0);
    rf_x1 = 32'h8000;
    step();
    for (int i = 0; i < 10 && !seen; i++) begin
      idle_in(); rf_x1 = 32'h8000; rs1_gnt = 1; rs1_rdata = 32'h8000;
      step();
      reqs += int'(rs1_req);
      seen = tgt_valid;
    end
    chk("jalr_x1_seen", 32'(seen), 32'd1);
    chk("jalr_x1_pc", tgt_pc, 32'h8000);
    chk("jalr_x1_reqs", 32'(reqs), FWD ? 32'd0 : 32'd1);
    idle_in(); step();

    // Counter saturation under a long oitf stall, then reset clears it
    present(0, 1, 0, 5'd6, 32'h800, 32'h0);
    step();
    for (int i = 0; i < 20; i++) begin
      idle_in(); oitf_empty = 0; step();
    end
    chk("stall_sat", 32'(stall_cnt), 32'd15);
    idle_in(); rst = 1; step();
    chk("stall_rst", 32'(stall_cnt), 32'd0);
    idle_in(); step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int k;
      idle_in();
      rst        = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 29) == 0);
      dec_valid  = ($urandom_range(0, 1) == 1);
      k          = $urandom_range(0, 3);
      dec_jal    = (k == 0);
      dec_jalr   = (k == 1);
      dec_bxx    = (k == 2);
      dec_jalr_rs1idx = 5'($urandom_range(0, 7));
      dec_bjp_imm = $urandom();
      pc          = $urandom();
      oitf_empty  = ($urandom_range(0, 9) < 7);
      ir_valid    = ($urandom_range(0, 1) == 1);
      ir_rden     = ($urandom_range(0, 1) == 1);
      ir_rdidx    = 5'($urandom_range(0, 7));
      rf_x1       = $urandom();
      rs1_gnt     = ($urandom_range(0, 9) < 4);
      rs1_rdata   = $urandom();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
